// File: rtl/lc3_pkg.sv
// Shared LC-3 condition-code definitions: bit positions, reset value and the NZP type.
package lc3_pkg;

    localparam int CC_N = 2;
    localparam int CC_Z = 1;
    localparam int CC_P = 0;

    typedef logic [2:0] nzp_t;

    // Z set after reset, matching an LC-3 that has just cleared its registers.
    localparam nzp_t NZP_RESET = 3'b010;

endpackage

// File: rtl/lc3_cc_unit_if.sv
// Control/data signals between the datapath controller and the condition-code unit.
interface lc3_cc_unit_if
    import lc3_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    logic                         i_LD_CC;
    logic [WIDTH-1:0]             i_Bus;
    logic                         i_LD_PSR_CC;
    logic                         i_LD_BEN;
    logic [2:0]                   i_IR_NZP;
    logic                         i_Push;
    logic                         i_Pop;
    logic                         i_Err_Clr;
    nzp_t                         o_NZP;
    logic                         o_BEN;
    logic [$clog2(DEPTH+1)-1:0]   o_Depth;
    logic                         o_Full;
    logic                         o_Empty;
    logic                         o_Overflow;
    logic                         o_Underflow;

    modport master (
        output i_LD_CC, i_Bus, i_LD_PSR_CC, i_LD_BEN, i_IR_NZP, i_Push, i_Pop, i_Err_Clr,
        input  o_NZP, o_BEN, o_Depth, o_Full, o_Empty, o_Overflow, o_Underflow
    );

    modport slave (
        input  i_LD_CC, i_Bus, i_LD_PSR_CC, i_LD_BEN, i_IR_NZP, i_Push, i_Pop, i_Err_Clr,
        output o_NZP, o_BEN, o_Depth, o_Full, o_Empty, o_Overflow, o_Underflow
    );

endinterface

// File: rtl/lc3_cc_stack.sv
// DEPTH-entry LIFO of saved NZP values for interrupt nesting.
// Push+pop on a non-empty stack swaps the top entry with the incoming value;
// push+pop on an empty stack behaves as a plain push.
module lc3_cc_stack
    import lc3_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int DW    = $clog2(DEPTH+1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clr,
    input  nzp_t          wr_nzp,
    output nzp_t          rd_nzp,
    output logic          rd_valid,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          underflow
);

    logic [DW-1:0] count;
    nzp_t          mem [2**AW];
    logic [AW-1:0] top_idx;
    logic [AW-1:0] push_idx;
    logic          do_push;
    logic          do_pop;
    logic          do_swap;
    logic          ovf_evt;
    logic          unf_evt;

    assign empty    = (count == '0);
    assign full     = (count == DW'(DEPTH));
    assign top_idx  = AW'(count - 1'b1);
    assign push_idx = AW'(count);

    assign do_swap  = push & pop & ~empty;
    assign do_push  = push & ~full & ~(pop & ~empty);
    assign do_pop   = pop & ~push & ~empty;
    assign ovf_evt  = push & ~pop & full;
    assign unf_evt  = pop & ~push & empty;

    assign rd_nzp   = mem[top_idx];
    assign rd_valid = pop & ~empty;
    assign depth    = count;

    // Occupancy counter; push and pop are mutually exclusive here, a swap leaves it alone.
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (do_push) begin
            count <= count + 1'b1;
        end else if (do_pop) begin
            count <= count - 1'b1;
        end
    end

    // Entry storage: push writes the next free slot, swap overwrites the current top.
    // NOTE: the storage array has no reset; its contents are meaningless while count is 0.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[push_idx] <= wr_nzp;
        end else if (do_swap) begin
            mem[top_idx] <= wr_nzp;
        end
    end

    // Sticky error flags; a new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt)  overflow  <= 1'b1;
            else if (clr) overflow  <= 1'b0;
            if (unf_evt)  underflow <= 1'b1;
            else if (clr) underflow <= 1'b0;
        end
    end

endmodule

// File: rtl/lc3_cc_unit.sv
// LC-3 condition-code unit: NZP register with bus-derived and PSR loads,
// registered branch enable and a save/restore stack for interrupt nesting.
module lc3_cc_unit
    import lc3_pkg::*;
#(
    parameter int   WIDTH     = 16,
    parameter int   DEPTH     = 4,
    parameter nzp_t RESET_NZP = NZP_RESET
) (
    input logic          i_CLK,
    input logic          i_RST,
    lc3_cc_unit_if.slave bus
);

    nzp_t nzp;
    nzp_t nzp_next;
    nzp_t cc_nzp;
    nzp_t stack_nzp;
    logic stack_valid;
    logic ben;

    lc3_cc_stack #(.DEPTH(DEPTH)) u_stack (
        .clk       (i_CLK),
        .rst       (i_RST),
        .push      (bus.i_Push),
        .pop       (bus.i_Pop),
        .clr       (bus.i_Err_Clr),
        .wr_nzp    (nzp),
        .rd_nzp    (stack_nzp),
        .rd_valid  (stack_valid),
        .depth     (bus.o_Depth),
        .full      (bus.o_Full),
        .empty     (bus.o_Empty),
        .overflow  (bus.o_Overflow),
        .underflow (bus.o_Underflow)
    );

    // Sign/zero decode of the bus; always exactly one bit set.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cc_nzp       = '0;
        cc_nzp[CC_N] = bus.i_Bus[WIDTH-1];
        cc_nzp[CC_Z] = (bus.i_Bus == '0);
        cc_nzp[CC_P] = ~cc_nzp[CC_N] & ~cc_nzp[CC_Z];
    end

    // Next-NZP priority: stack restore, then PSR load (verbatim low bits), then bus decode.
    always_comb begin
        nzp_next = nzp;
        if (stack_valid) begin
            nzp_next = stack_nzp;
        end else if (bus.i_LD_PSR_CC) begin
            nzp_next = nzp_t'(bus.i_Bus);
        end else if (bus.i_LD_CC) begin
            nzp_next = cc_nzp;
        end
    end

    // NZP and BEN registers; BEN evaluates against the NZP held before this edge.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            nzp <= RESET_NZP;
            ben <= 1'b0;
        end else begin
            nzp <= nzp_next;
            if (bus.i_LD_BEN) ben <= |(bus.i_IR_NZP & nzp);
        end
    end

    assign bus.o_NZP = nzp;
    assign bus.o_BEN = ben;

endmodule

// File: tb/tb_lc3_cc_unit.sv
// Self-checking bench for lc3_cc_unit: directed cases for each documented corner,
// then randomized traffic against a queue-based reference model.
module tb_lc3_cc_unit;
    import lc3_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lc3_cc_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    lc3_cc_unit_if #(.WIDTH(8), .DEPTH(2)) bus8 ();

    lc3_cc_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_NZP(3'b010)) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus)
    );

    lc3_cc_unit #(.WIDTH(8), .DEPTH(2), .RESET_NZP(3'b010)) dut8 (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus8)
    );

    // Reference model state
    nzp_t m_nzp;
    bit   m_ben;
    nzp_t m_stack[$];
    bit   m_ovf;
    bit   m_unf;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic nzp_t ref_cc(input logic [WIDTH-1:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 0)         return 3'b010;
        return 3'b001;
    endfunction

    task automatic model_reset();
        m_nzp = 3'b010;
        m_ben = 1'b0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_step();
        nzp_t old     = m_nzp;
        bit   pop_ok  = bus.i_Pop && (m_stack.size() > 0);
        bit   ovf_evt = 1'b0;
        bit   unf_evt = 1'b0;
        if (bus.i_LD_BEN) m_ben = ((bus.i_IR_NZP & old) != 3'b000);
        if (bus.i_Push && pop_ok) begin
            m_nzp = m_stack[m_stack.size()-1];
            m_stack[m_stack.size()-1] = old;
        end else begin
            if (bus.i_Push) begin
                if (m_stack.size() < DEPTH) m_stack.push_back(old);
                else ovf_evt = 1'b1;
            end else if (bus.i_Pop) begin
                if (pop_ok) m_nzp = m_stack.pop_back();
                else unf_evt = 1'b1;
            end
            if (!pop_ok) begin
                if (bus.i_LD_PSR_CC)  m_nzp = bus.i_Bus[2:0];
                else if (bus.i_LD_CC) m_nzp = ref_cc(bus.i_Bus);
            end
        end
        if (ovf_evt) m_ovf = 1'b1; else if (bus.i_Err_Clr) m_ovf = 1'b0;
        if (unf_evt) m_unf = 1'b1; else if (bus.i_Err_Clr) m_unf = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".nzp"},   bus.o_NZP,       m_nzp);
        check({tag, ".ben"},   bus.o_BEN,       m_ben);
        check({tag, ".depth"}, bus.o_Depth,     m_stack.size());
        check({tag, ".full"},  bus.o_Full,      m_stack.size() == DEPTH);
        check({tag, ".empty"}, bus.o_Empty,     m_stack.size() == 0);
        check({tag, ".ovf"},   bus.o_Overflow,  m_ovf);
        check({tag, ".unf"},   bus.o_Underflow, m_unf);
    endtask

    task automatic idle();
        bus.i_LD_CC     = 1'b0;
        bus.i_Bus       = '0;
        bus.i_LD_PSR_CC = 1'b0;
        bus.i_LD_BEN    = 1'b0;
        bus.i_IR_NZP    = 3'b000;
        bus.i_Push      = 1'b0;
        bus.i_Pop       = 1'b0;
        bus.i_Err_Clr   = 1'b0;
    endtask

    // Apply one cycle of inputs, clock it, then compare everything 1 time unit after the edge.
    task automatic op(input string tag, input bit ld_cc, input logic [WIDTH-1:0] b,
                      input bit psr, input bit ld_ben, input logic [2:0] ir,
                      input bit push, input bit pop, input bit clr);
        bus.i_LD_CC     = ld_cc;
        bus.i_Bus       = b;
        bus.i_LD_PSR_CC = psr;
        bus.i_LD_BEN    = ld_ben;
        bus.i_IR_NZP    = ir;
        bus.i_Push      = push;
        bus.i_Pop       = pop;
        bus.i_Err_Clr   = clr;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus8.i_LD_CC = 1'b0; bus8.i_Bus = '0; bus8.i_LD_PSR_CC = 1'b0; bus8.i_LD_BEN = 1'b0;
        bus8.i_IR_NZP = 3'b000; bus8.i_Push = 1'b0; bus8.i_Pop = 1'b0; bus8.i_Err_Clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // CC generation
        op("cc_8000", 1, 16'h8000, 0, 0, 3'b000, 0, 0, 0);
        check("cc_8000_const", bus.o_NZP, 3'b100);
        op("cc_0000", 1, 16'h0000, 0, 0, 3'b000, 0, 0, 0);
        check("cc_0000_const", bus.o_NZP, 3'b010);
        op("cc_7fff", 1, 16'h7FFF, 0, 0, 3'b000, 0, 0, 0);
        check("cc_7fff_const", bus.o_NZP, 3'b001);
        op("cc_ffff", 1, 16'hFFFF, 0, 0, 3'b000, 0, 0, 0);
        check("cc_ffff_const", bus.o_NZP, 3'b100);
        op("psr_ld",  1, 16'h0007, 1, 0, 3'b000, 0, 0, 0);
        check("psr_verbatim", bus.o_NZP, 3'b111);

        // BEN, including a same-cycle NZP load that must not be seen
        op("ben_pre", 1, 16'h7FFF, 0, 0, 3'b000, 0, 0, 0);
        op("ben_011", 0, 16'h0000, 0, 1, 3'b011, 0, 0, 0);
        check("ben_011_const", bus.o_BEN, 1'b1);
        op("ben_old", 1, 16'h0000, 0, 1, 3'b001, 0, 0, 0);
        check("ben_old_const", bus.o_BEN, 1'b1);
        check("ben_old_nzp",   bus.o_NZP, 3'b010);

        // Fill the stack with 100,010,001,100 then overflow
        op("st_pre", 0, 16'h0004, 1, 0, 3'b000, 0, 0, 0);
        op("push1",  0, 16'h0002, 1, 0, 3'b000, 1, 0, 0);
        op("push2",  0, 16'h0001, 1, 0, 3'b000, 1, 0, 0);
        op("push3",  0, 16'h0004, 1, 0, 3'b000, 1, 0, 0);
        op("push4",  0, 16'h0000, 0, 0, 3'b000, 1, 0, 0);
        check("full_const", bus.o_Full, 1'b1);
        op("push5",  0, 16'h0000, 0, 0, 3'b000, 1, 0, 0);
        check("ovf_const",   bus.o_Overflow, 1'b1);
        check("depth_const", bus.o_Depth, 3'd4);
        op("pop1", 1, 16'h0000, 0, 0, 3'b000, 0, 1, 0);
        check("pop1_const", bus.o_NZP, 3'b100);
        op("pop2", 0, 16'h0000, 1, 0, 3'b000, 0, 1, 0);
        check("pop2_const", bus.o_NZP, 3'b001);
        op("pop3", 0, 16'h0000, 0, 0, 3'b000, 0, 1, 0);
        check("pop3_const", bus.o_NZP, 3'b010);
        op("pop4", 0, 16'h0000, 0, 0, 3'b000, 0, 1, 0);
        check("pop4_const", bus.o_NZP, 3'b100);
        check("empty_const", bus.o_Empty, 1'b1);

        // Underflow and sticky-flag clearing
        op("unf",     1, 16'h0005, 0, 0, 3'b000, 0, 1, 0);
        check("unf_nzp_const", bus.o_NZP, 3'b001);
        check("unf_const",     bus.o_Underflow, 1'b1);
        op("clr",     0, 16'h0000, 0, 0, 3'b000, 0, 0, 1);
        check("clr_const", bus.o_Underflow, 1'b0);
        op("clr_unf", 0, 16'h0000, 0, 0, 3'b000, 0, 1, 1);
        check("clr_unf_const", bus.o_Underflow, 1'b1);
        op("clr2",    0, 16'h0000, 0, 0, 3'b000, 0, 0, 1);

        // Push+Pop swap at depth 1, then at depth 0
        op("sw_pre",  0, 16'h0004, 1, 0, 3'b000, 0, 0, 0);
        op("sw_push", 0, 16'h0001, 1, 0, 3'b000, 1, 0, 0);
        op("swap",    0, 16'h0000, 0, 0, 3'b000, 1, 1, 0);
        check("swap_nzp_const",   bus.o_NZP, 3'b100);
        check("swap_depth_const", bus.o_Depth, 3'd1);
        op("sw_pop",  0, 16'h0000, 0, 0, 3'b000, 0, 1, 0);
        check("swap_top_const",   bus.o_NZP, 3'b001);
        op("sw_zero", 0, 16'h0000, 0, 0, 3'b000, 1, 1, 0);
        check("sw0_depth_const",  bus.o_Depth, 3'd1);
        check("sw0_unf_const",    bus.o_Underflow, 1'b0);

        // Asynchronous reset mid-cycle, with non-reset state present
        op("ar_push", 0, 16'h0000, 0, 0, 3'b000, 1, 0, 0);
        op("ar_ben",  0, 16'h0000, 0, 1, 3'b111, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_nzp_const", bus.o_NZP, 3'b010);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [WIDTH-1:0] b;
            case ($urandom_range(3))
                0:       b = '0;
                1:       b = 16'h8000 | 16'($urandom);
                default: b = 16'($urandom);
            endcase
            op("rand", ($urandom_range(1) == 1), b, ($urandom_range(4) == 0),
               ($urandom_range(2) == 0), 3'($urandom), ($urandom_range(9) < 3),
               ($urandom_range(9) < 3), ($urandom_range(9) == 0));
        end

        // WIDTH=8 instance: sign bit is bit 7
        bus8.i_LD_CC = 1'b1;
        bus8.i_Bus   = 8'h80;
        @(posedge clk);
        #1;
        check("w8_80", bus8.o_NZP, 3'b100);
        bus8.i_Bus   = 8'h7F;
        @(posedge clk);
        #1;
        check("w8_7f", bus8.o_NZP, 3'b001);
        bus8.i_LD_CC = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
